sd_spi_reader: RTL

//  SPI-mode-0 master that reads 16-bit words from the SD card over MISO; receive-side companion of the SD write path.

---
 rtl/sd_spi_pkg.sv | 23 ++
 rtl/sd_spi_reader_if.sv | 30 +++
 rtl/sd_crc16_serial.sv | 25 ++
 rtl/sd_spi_reader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared FSM encodings and CRC16-CCITT helper for the SD SPI read path.
// Used by sd_spi_reader and sd_crc16_serial.
package sd_spi_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_CRC   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic        bit_in
    );
        logic fb;
        fb = crc[15] ^ bit_in;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_spi_reader_if.sv
// sd_spi_reader_if: host-side word handshake plus SD card SPI pins.
// master = the reader block, slave = host/consumer and card.
interface sd_spi_reader_if #(
    parameter int WORD_W = 16
);
    logic              start;
    logic [7:0]        num_words;
    logic              data_ready;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              done;
    logic              crc_err;
    logic              sclk;
    logic              mosi;
    logic              cs;
    logic              miso;

    modport master (
        input  start, num_words, data_ready, miso,
        output data_out, data_valid, busy, done, crc_err,
        output sclk, mosi, cs
    );

    modport slave (
        output start, num_words, data_ready, miso,
        input  data_out, data_valid, busy, done, crc_err,
        input  sclk, mosi, cs
    );
endinterface

// File: rtl/sd_crc16_serial.sv
// sd_crc16_serial: bit-serial CRC16-CCITT (poly 0x1021, init 0) accumulator.
module sd_crc16_serial
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_en,
    input  logic        clear,
    output logic [15:0] crc
);
    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 16'h0000;
        end else if (clear) begin
            r_crc <= 16'h0000;
        end else if (bit_en) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;
endmodule

// File: rtl/sd_spi_reader.sv
// sd_spi_reader: SPI mode-0 burst reader, one word per valid/ready handshake.
// Define SD_READ_CRC_EN to read and check a trailing CRC16 word after the burst.
module sd_spi_reader
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 16
) (
    input logic             clk,
    input logic             rst_n,
    sd_spi_reader_if.master bus
);
    localparam int H  = CLK_DIV / 2;
    localparam int CW = ($clog2(H) > 0) ? $clog2(H) : 1;
    localparam int BW = $clog2(WORD_W + 1);

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bits;
    logic [7:0]        r_words;
    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] r_data;
    logic              r_sclk;
    logic              r_cs;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic w_run;
    logic w_tick;
    logic w_shift;
    logic w_rise;
    logic w_word_end;
    logic w_accept;
    logic w_start_ok;

    assign w_start_ok = (r_state == S_IDLE) && bus.start
                        && (bus.num_words != 8'd0);
`ifdef SD_READ_CRC_EN
    assign w_shift = (r_state == S_SHIFT) || (r_state == S_CRC);
`else
    assign w_shift = (r_state == S_SHIFT);
`endif
    assign w_run = (r_state == S_SETUP) || w_shift || (r_state == S_DONE);
    assign w_tick = w_run && (r_cnt == CW'(H - 1));
    assign w_rise = w_shift && w_tick && !r_sclk;
    assign w_word_end = w_shift && w_tick && r_sclk
                        && (r_bits == BW'(WORD_W));
    assign w_accept = (r_state == S_HOLD) && r_valid && bus.data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_words <= 8'd0;
            r_shreg <= '0;
            r_data  <= '0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // every state change happens on a tick or from an untimed state,
            // so the half-period counter is always zero on state entry
            r_cnt <= (w_run && !w_tick) ? r_cnt + CW'(1) : '0;
            if (w_shift && w_tick) r_sclk <= ~r_sclk;
            if (w_rise) begin
                r_shreg <= {r_shreg[WORD_W-2:0], bus.miso};
                r_bits  <= r_bits + BW'(1);
            end
            if (w_word_end) r_bits <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_words <= bus.num_words;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tick) r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_word_end) begin
                        r_data  <= r_shreg;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_words <= r_words - 8'd1;
                        if (r_words != 8'd1) begin
                            r_state <= S_SHIFT;
                        end else begin
`ifdef SD_READ_CRC_EN
                            r_state <= S_CRC;
`else
                            r_cs    <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end
                    end
                end
`ifdef SD_READ_CRC_EN
                S_CRC: begin
                    if (w_word_end) begin
                        r_cs    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SD_READ_CRC_EN
    logic [15:0] w_crc;
    logic        r_crc_err;

    sd_crc16_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .bit_in (bus.miso),
        .bit_en (w_rise && (r_state == S_SHIFT)),
        .clear  (w_start_ok),
        .crc    (w_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_err <= 1'b0;
        end else if (w_start_ok) begin
            r_crc_err <= 1'b0;
        end else if ((r_state == S_CRC) && w_word_end) begin
            r_crc_err <= (r_shreg[15:0] != w_crc);
        end
    end

    assign bus.crc_err = r_crc_err;
`else
    assign bus.crc_err = 1'b0;
`endif

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sclk       = r_sclk;
    assign bus.cs         = r_cs;
    assign bus.mosi       = 1'b1;
endmodule
